// File: rtl/crosp_axi_mux.sv
// crosp_axi_mux: N:1 AXI4 master mux sharing one AXI port among CROSP cores.
// Arbitrated AR/AW with outstanding limits, ID-routed R/B, W order FIFO.

module crosp_axi_mux_ach #(
    parameter int nmst = 4,
    parameter int maxo = 8,
    parameter int arb  = 0,
    parameter int pw   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [nmst-1:0]              s_valid,
    input  logic [nmst-1:0][pw-1:0]      s_pl,
    input  logic                         s_ok,
    input  logic [nmst-1:0]              dec,
    output logic [nmst-1:0]              s_ready,
    output logic                         m_valid,
    output logic [$clog2(nmst)-1:0]      m_idx,
    output logic [pw-1:0]                m_pl,
    input  logic                         m_ready
);
    localparam int mw = $clog2(nmst);
    localparam int cw = $clog2(maxo + 1);

    logic [nmst-1:0][cw-1:0] cnt;
    logic [nmst-1:0]         elig;
    logic [mw-1:0]           ptr;
    logic [mw-1:0]           win;
    logic                    found;
    logic                    load;
    logic                    go;
    int                      j;

    assign load = !m_valid || m_ready;
    assign go   = rst && load && found;

    always_comb begin
        elig = '0;
        for (int i = 0; i < nmst; i++)
            elig[i] = s_valid[i] && s_ok && (cnt[i] < cw'(maxo));
    end

    // Scan starts at ptr for round-robin, at 0 for fixed priority
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = 0; k < nmst; k++) begin
            j = (arb == 1) ? k : (int'(ptr) + k) % nmst;
            if (!found && elig[j]) begin
                found = 1'b1;
                win   = mw'(j);
            end
        end
    end

    always_comb begin
        s_ready = '0;
        for (int i = 0; i < nmst; i++)
            s_ready[i] = go && (win == mw'(i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_idx   <= '0;
            m_pl    <= '0;
            ptr     <= '0;
        end else if (load) begin
            m_valid <= go;
            if (go) begin
                m_idx <= win;
                m_pl  <= s_pl[win];
                ptr   <= mw'((int'(win) + 1) % nmst);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < nmst; i++) begin
                if (s_ready[i] && !dec[i])
                    cnt[i] <= cnt[i] + cw'(1);
                else if (!s_ready[i] && dec[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - cw'(1);
            end
        end
    end
endmodule

module crosp_axi_mux #(
    parameter int nmst = 4,
    parameter int sidw = 6,
    parameter int aw   = 64,
    parameter int dw   = 64,
    parameter int maxo = 8,
    parameter int wfsz = 4,
    parameter int arb  = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [nmst-1:0][sidw-1:0]         s_axi_arid,
    input  logic [nmst-1:0][aw-1:0]           s_axi_araddr,
    input  logic [nmst-1:0][7:0]              s_axi_arlen,
    input  logic [nmst-1:0][2:0]              s_axi_arsize,
    input  logic [nmst-1:0][1:0]              s_axi_arburst,
    input  logic [nmst-1:0]                   s_axi_arlock,
    input  logic [nmst-1:0][3:0]              s_axi_arcache,
    input  logic [nmst-1:0][2:0]              s_axi_arprot,
    input  logic [nmst-1:0][3:0]              s_axi_arqos,
    input  logic [nmst-1:0]                   s_axi_arvalid,
    output logic [nmst-1:0]                   s_axi_arready,
    input  logic [nmst-1:0][sidw-1:0]         s_axi_awid,
    input  logic [nmst-1:0][aw-1:0]           s_axi_awaddr,
    input  logic [nmst-1:0][7:0]              s_axi_awlen,
    input  logic [nmst-1:0][2:0]              s_axi_awsize,
    input  logic [nmst-1:0][1:0]              s_axi_awburst,
    input  logic [nmst-1:0]                   s_axi_awlock,
    input  logic [nmst-1:0][3:0]              s_axi_awcache,
    input  logic [nmst-1:0][2:0]              s_axi_awprot,
    input  logic [nmst-1:0][3:0]              s_axi_awqos,
    input  logic [nmst-1:0]                   s_axi_awvalid,
    output logic [nmst-1:0]                   s_axi_awready,
    input  logic [nmst-1:0][dw-1:0]           s_axi_wdata,
    input  logic [nmst-1:0][dw/8-1:0]         s_axi_wstrb,
    input  logic [nmst-1:0]                   s_axi_wlast,
    input  logic [nmst-1:0]                   s_axi_wvalid,
    output logic [nmst-1:0]                   s_axi_wready,
    output logic [nmst-1:0][sidw-1:0]         s_axi_rid,
    output logic [nmst-1:0][dw-1:0]           s_axi_rdata,
    output logic [nmst-1:0][1:0]              s_axi_rresp,
    output logic [nmst-1:0]                   s_axi_rlast,
    output logic [nmst-1:0]                   s_axi_rvalid,
    input  logic [nmst-1:0]                   s_axi_rready,
    output logic [nmst-1:0][sidw-1:0]         s_axi_bid,
    output logic [nmst-1:0][1:0]              s_axi_bresp,
    output logic [nmst-1:0]                   s_axi_bvalid,
    input  logic [nmst-1:0]                   s_axi_bready,
    output logic [sidw+$clog2(nmst)-1:0]      m_axi_arid,
    output logic [aw-1:0]                     m_axi_araddr,
    output logic [7:0]                        m_axi_arlen,
    output logic [2:0]                        m_axi_arsize,
    output logic [1:0]                        m_axi_arburst,
    output logic                              m_axi_arlock,
    output logic [3:0]                        m_axi_arcache,
    output logic [2:0]                        m_axi_arprot,
    output logic [3:0]                        m_axi_arqos,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    output logic [sidw+$clog2(nmst)-1:0]      m_axi_awid,
    output logic [aw-1:0]                     m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic                              m_axi_awlock,
    output logic [3:0]                        m_axi_awcache,
    output logic [2:0]                        m_axi_awprot,
    output logic [3:0]                        m_axi_awqos,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [dw-1:0]                     m_axi_wdata,
    output logic [dw/8-1:0]                   m_axi_wstrb,
    output logic                              m_axi_wlast,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [sidw+$clog2(nmst)-1:0]      m_axi_rid,
    input  logic [dw-1:0]                     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rlast,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready,
    input  logic [sidw+$clog2(nmst)-1:0]      m_axi_bid,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready
);
    localparam int mw  = $clog2(nmst);
    localparam int miw = sidw + mw;
    localparam int pw  = sidw + aw + 25;
    localparam int fw  = $clog2(wfsz);

    logic [nmst-1:0][pw-1:0] ar_pl, aw_pl;
    logic [pw-1:0]           ar_q, aw_q;
    logic [mw-1:0]           ar_idx, aw_idx, aw_win;
    logic [sidw-1:0]         ar_id_lo, aw_id_lo;
    logic [nmst-1:0]         rd_dec, wr_dec;
    logic                    aw_go;
    logic                    wf_full, wf_empty, w_have, w_pop;
    logic [mw-1:0]           w_idx;
    logic [mw-1:0]           wq [wfsz];
    logic [fw-1:0]           wr_p, rd_p;
    logic [fw:0]             wcnt;
    logic [mw-1:0]           rdst, bdst;
    logic                    r_ok, b_ok;

    always_comb begin
        ar_pl = '0;
        aw_pl = '0;
        for (int i = 0; i < nmst; i++) begin
            ar_pl[i] = {s_axi_arid[i], s_axi_araddr[i], s_axi_arlen[i],
                        s_axi_arsize[i], s_axi_arburst[i], s_axi_arlock[i],
                        s_axi_arcache[i], s_axi_arprot[i], s_axi_arqos[i]};
            aw_pl[i] = {s_axi_awid[i], s_axi_awaddr[i], s_axi_awlen[i],
                        s_axi_awsize[i], s_axi_awburst[i], s_axi_awlock[i],
                        s_axi_awcache[i], s_axi_awprot[i], s_axi_awqos[i]};
        end
    end

    crosp_axi_mux_ach #(.nmst(nmst), .maxo(maxo), .arb(arb), .pw(pw)) u_ar (
        .clk(clk), .rst(rst), .s_valid(s_axi_arvalid), .s_pl(ar_pl),
        .s_ok(1'b1), .dec(rd_dec), .s_ready(s_axi_arready),
        .m_valid(m_axi_arvalid), .m_idx(ar_idx), .m_pl(ar_q),
        .m_ready(m_axi_arready)
    );

    crosp_axi_mux_ach #(.nmst(nmst), .maxo(maxo), .arb(arb), .pw(pw)) u_aw (
        .clk(clk), .rst(rst), .s_valid(s_axi_awvalid), .s_pl(aw_pl),
        .s_ok(!wf_full), .dec(wr_dec), .s_ready(s_axi_awready),
        .m_valid(m_axi_awvalid), .m_idx(aw_idx), .m_pl(aw_q),
        .m_ready(m_axi_awready)
    );

    assign {ar_id_lo, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
            m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos} = ar_q;
    assign {aw_id_lo, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
            m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos} = aw_q;
    assign m_axi_arid = {ar_idx, ar_id_lo};
    assign m_axi_awid = {aw_idx, aw_id_lo};

    assign aw_go = |s_axi_awready;

    always_comb begin
        aw_win = '0;
        for (int i = 0; i < nmst; i++)
            if (s_axi_awready[i]) aw_win = mw'(i);
    end

    // An empty FIFO lets the AW being granted this cycle steer W directly
    assign wf_full  = wcnt == (fw+1)'(wfsz);
    assign wf_empty = wcnt == '0;
    assign w_have   = !wf_empty || aw_go;
    assign w_idx    = wf_empty ? aw_win : wq[rd_p];

    assign m_axi_wvalid = w_have && s_axi_wvalid[w_idx];
    assign m_axi_wdata  = s_axi_wdata[w_idx];
    assign m_axi_wstrb  = s_axi_wstrb[w_idx];
    assign m_axi_wlast  = s_axi_wlast[w_idx];
    assign w_pop        = m_axi_wvalid && m_axi_wready && m_axi_wlast;

    always_comb begin
        s_axi_wready = '0;
        for (int i = 0; i < nmst; i++)
            s_axi_wready[i] = w_have && m_axi_wready && (w_idx == mw'(i));
    end

    always_ff @(posedge clk) begin
        if (aw_go) wq[wr_p] <= aw_win;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_p <= '0;
            rd_p <= '0;
            wcnt <= '0;
        end else begin
            if (aw_go) wr_p <= wr_p + fw'(1);
            if (w_pop) rd_p <= rd_p + fw'(1);
            wcnt <= wcnt + (fw+1)'(aw_go) - (fw+1)'(w_pop);
        end
    end

    // Out-of-range prefixes are swallowed so the slave never stalls on them
    assign rdst = m_axi_rid[miw-1 -: mw];
    assign bdst = m_axi_bid[miw-1 -: mw];
    assign r_ok = int'(rdst) < nmst;
    assign b_ok = int'(bdst) < nmst;
    assign m_axi_rready = rst && (r_ok ? s_axi_rready[rdst] : 1'b1);
    assign m_axi_bready = rst && (b_ok ? s_axi_bready[bdst] : 1'b1);

    always_comb begin
        s_axi_rvalid = '0;
        s_axi_bvalid = '0;
        rd_dec       = '0;
        wr_dec       = '0;
        s_axi_rid    = '0;
        s_axi_rdata  = '0;
        s_axi_rresp  = '0;
        s_axi_rlast  = '0;
        s_axi_bid    = '0;
        s_axi_bresp  = '0;
        for (int i = 0; i < nmst; i++) begin
            s_axi_rvalid[i] = rst && m_axi_rvalid && r_ok && (rdst == mw'(i));
            s_axi_bvalid[i] = rst && m_axi_bvalid && b_ok && (bdst == mw'(i));
            s_axi_rid[i]    = m_axi_rid[sidw-1:0];
            s_axi_rdata[i]  = m_axi_rdata;
            s_axi_rresp[i]  = m_axi_rresp;
            s_axi_rlast[i]  = m_axi_rlast;
            s_axi_bid[i]    = m_axi_bid[sidw-1:0];
            s_axi_bresp[i]  = m_axi_bresp;
            rd_dec[i] = s_axi_rvalid[i] && s_axi_rready[i] && m_axi_rlast;
            wr_dec[i] = s_axi_bvalid[i] && s_axi_bready[i];
        end
    end
endmodule
